stall_ctrl: RTL and testbench
=============================

# stall_ctrl

Pipeline hazard scheduler for the five-stage MIPS core. It decides each cycle whether the D-stage instruction may advance, or whether F/D must be frozen and a bubble injected into E. The decision uses Tuse/Tnew hazard analysis against the producers in E and M, plus a cycle counter that models the multi-cycle mult/div unit. The block sits beside the forwarding units: anything the forwarding network cannot cover in time is converted here into a stall.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu issues from E
- DIV_CYCLES, 10, busy cycles after a div/divu issues from E
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rs_D, rt_D  in  5 each  source register numbers of the D instruction
- tuse_rs_D, tuse_rt_D  in  2 each  cycles until the D instruction needs rs/rt (3 = never used)
- write_reg_E, write_reg_M  in  5 each  destination register in E and M
- reg_write_E, reg_write_M  in  1 each  destination is written
- tnew_E, tnew_M  in  2 each  cycles until the result is available for forwarding
- md_start_E  in  1  mult/div is in E this cycle, one pulse per instruction
- md_is_div_E  in  1  1 = div/divu, 0 = mult/multu; qualified by md_start_E
- md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- en_PC  out  1  PC write enable
- en_D  out  1  F/D register write enable
- flush_E  out  1  clear the D/E register (bubble)
- md_busy  out  1  mult/div unit is busy
- stall_count  out  32  stall cycles counted (present only with STALL_CNT_EN)

## Operation
- Register hazard on rs: rs_D != 0 and either
  - reg_write_E && write_reg_E == rs_D && tnew_E > tuse_rs_D, or
  - reg_write_M && write_reg_M == rs_D && tnew_M > tuse_rs_D.
- Register hazard on rt: same rule using rt_D and tuse_rt_D.
- A hazard is raised only on strict greater-than. Equality is resolved by forwarding.
- tuse = 3 never stalls.
- MD counter (md_cnt), 4 bits wide:
  - On md_start_E, load MULT_CYCLES or DIV_CYCLES.
  - Otherwise, decrement while nonzero. Saturate at 0.
- md_busy = md_start_E || (md_cnt != 0).
- MD hazard = md_use_D && md_busy.
- stall = rs hazard || rt hazard || MD hazard.
- Outputs:
  - en_PC = en_D = ~stall.
  - flush_E = stall.
- md_start_E while md_cnt != 0 is illegal in normal flow, because D is stalled. If it occurs, the counter reloads and the previous count is discarded.
- Parameters must be 1..15. Elaboration fails otherwise.

## Timing
- stall, en_PC, en_D, flush_E and md_busy are combinational from inputs and md_cnt. Zero-cycle latency.
- md_cnt updates on the rising clk edge.
- Example for mult issued in cycle t: md_busy is 1 in cycles t through t+5 inclusive, which is 1 + MULT_CYCLES cycles. md_busy is 0 at t+6.
- The D instruction using HI/LO advances in the first cycle md_busy is 0.
- reset_n low, at any time and asynchronously: md_cnt = 0 and stall_count = 0. Combinational outputs then reflect the inputs only, so they are en_PC = en_D = 1, flush_E = 0 and md_busy = 0 when no hazard inputs are active.
- Reset during a mult/div in flight drops the busy state immediately.

## Configuration
- STALL_CNT_EN defined:
  - stall_count increments by 1 on every clk edge where stall = 1.
  - It wraps from 0xFFFF_FFFF to 0.
  - It is cleared by reset.
- STALL_CNT_EN undefined: the stall_count port and its register are absent. No other behaviour changes.

## Structure
- Shared package `hazard_pkg` holds:
  - TUSE_NEVER = 2'd3
  - the MULT_CYCLES/DIV_CYCLES defaults
  - the Tuse/Tnew width constant (2)
- Sub-module `md_busy_cnt` contains the loadable down-counter and md_busy. The hazard compare logic stays in the top module.

## Test plan
- lw $1 in E (tnew_E = 2), D = addu using $1 (tuse_rs_D = 1) -> stall = 1, en_PC = 0, flush_E = 1. Next cycle with tnew_M = 1 -> stall = 0.
- write_reg_E = 0, rs_D = 0, reg_write_E = 1, tnew_E = 2 -> stall = 0 (the $0 exemption).
- addu $2 in M (tnew_M = 0), D = beq on $2 (tuse_rt_D = 0) -> stall = 0, covered by forwarding.
- mult at cycle t, then mflo held in D (md_use_D = 1) -> stall high for cycles t..t+5, low at t+6. div gives stall high for t..t+10.
- mult at t, reset_n pulled low at t+2 and released -> md_busy = 0 during reset and after release. stall_count = 0.
- With STALL_CNT_EN: three lw-use stalls plus one mult/mflo sequence -> stall_count = 3 + 6 = 9.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: constants and types shared by the stall_ctrl hazard scheduler.
//   TUSE_NEVER        - Tuse encoding meaning the operand is never read
//   T_WIDTH           - width of the Tuse/Tnew fields
//   MD_CNT_WIDTH      - width of the mult/div busy counter
//   MULT_CYCLES_DEF   - default busy cycles after a mult/multu issues
//   DIV_CYCLES_DEF    - default busy cycles after a div/divu issues
package hazard_pkg;

    localparam int unsigned T_WIDTH         = 2;
    localparam int unsigned MD_CNT_WIDTH    = 4;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    localparam logic [T_WIDTH-1:0] TUSE_NEVER = 2'd3;

    typedef enum logic {
        MD_MULT = 1'b0,
        MD_DIV  = 1'b1
    } mdOp_e;

endpackage

// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: hazard inputs from the D/E/M stages and the stall decisions
// returned to the pipeline.
//   slave  - the scheduler (consumes stage info, drives enables/flush/busy)
//   master - the pipeline side (drives stage info, consumes the decisions)
interface stall_ctrl_if;
    import hazard_pkg::*;

    logic [4:0]         rs_D;
    logic [4:0]         rt_D;
    logic [T_WIDTH-1:0] tuse_rs_D;
    logic [T_WIDTH-1:0] tuse_rt_D;
    logic [4:0]         write_reg_E;
    logic [4:0]         write_reg_M;
    logic               reg_write_E;
    logic               reg_write_M;
    logic [T_WIDTH-1:0] tnew_E;
    logic [T_WIDTH-1:0] tnew_M;
    logic               md_start_E;
    logic               md_is_div_E;
    logic               md_use_D;
    logic               en_PC;
    logic               en_D;
    logic               flush_E;
    logic               md_busy;

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D,
        input  write_reg_E, write_reg_M, reg_write_E, reg_write_M,
        input  tnew_E, tnew_M, md_start_E, md_is_div_E, md_use_D,
        output en_PC, en_D, flush_E, md_busy
    );

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D,
        output write_reg_E, write_reg_M, reg_write_E, reg_write_M,
        output tnew_E, tnew_M, md_start_E, md_is_div_E, md_use_D,
        input  en_PC, en_D, flush_E, md_busy
    );

endinterface

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: models the multi-cycle mult/div unit occupancy.
//   clk, reset_n   - clock, asynchronous active-low reset
//   md_start_E     - mult/div issuing from E (one pulse per instruction)
//   md_is_div_E    - 1 = div/divu, 0 = mult/multu
//   md_busy        - unit busy this cycle (includes the issue cycle)
module md_busy_cnt
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic md_start_E,
    input  logic md_is_div_E,
    output logic md_busy
);

    if (MULT_CYCLES < 1 || MULT_CYCLES > 15)
        $error("md_busy_cnt: MULT_CYCLES must be within 1..15");
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15)
        $error("md_busy_cnt: DIV_CYCLES must be within 1..15");

    localparam logic [MD_CNT_WIDTH-1:0] MULT_LOAD = MD_CNT_WIDTH'(MULT_CYCLES);
    localparam logic [MD_CNT_WIDTH-1:0] DIV_LOAD  = MD_CNT_WIDTH'(DIV_CYCLES);

    logic [MD_CNT_WIDTH-1:0] mdCnt;
    mdOp_e                   mdOp;

    assign mdOp = mdOp_e'(md_is_div_E);

    // A start while still counting reloads; the old count is simply dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdCnt <= '0;
        end else if (md_start_E) begin
            mdCnt <= (mdOp == MD_DIV) ? DIV_LOAD : MULT_LOAD;
        end else if (mdCnt != '0) begin
            mdCnt <= mdCnt - 1'b1;
        end
    end

    assign md_busy = md_start_E || (mdCnt != '0);

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: Tuse/Tnew hazard scheduler for the five-stage MIPS pipeline.
// Freezes PC and F/D and injects a bubble into E whenever a D operand cannot
// be forwarded in time or D touches HI/LO while mult/div is still busy.
//   clk, reset_n  - clock, asynchronous active-low reset
//   bus (slave)   - stage info in; en_PC, en_D, flush_E, md_busy out
//   stall_count   - stall cycles counted (only when STALL_CNT_EN is defined)
// Optional feature macro: STALL_CNT_EN.
module stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    stall_ctrl_if.slave        bus
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]        stall_count
`endif
);

    logic rsHazard;
    logic rtHazard;
    logic mdHazard;
    logic stall;
    logic mdBusy;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) uMdBusyCnt (
        .clk         (clk),
        .reset_n     (reset_n),
        .md_start_E  (bus.md_start_E),
        .md_is_div_E (bus.md_is_div_E),
        .md_busy     (mdBusy)
    );

    // Only strict Tnew > Tuse stalls; equality is covered by forwarding.
    always_comb begin
        rsHazard = 1'b0;
        rtHazard = 1'b0;
        if (bus.rs_D != 5'd0 && bus.tuse_rs_D != TUSE_NEVER) begin
            rsHazard = (bus.reg_write_E && bus.write_reg_E == bus.rs_D &&
                        bus.tnew_E > bus.tuse_rs_D) ||
                       (bus.reg_write_M && bus.write_reg_M == bus.rs_D &&
                        bus.tnew_M > bus.tuse_rs_D);
        end
        if (bus.rt_D != 5'd0 && bus.tuse_rt_D != TUSE_NEVER) begin
            rtHazard = (bus.reg_write_E && bus.write_reg_E == bus.rt_D &&
                        bus.tnew_E > bus.tuse_rt_D) ||
                       (bus.reg_write_M && bus.write_reg_M == bus.rt_D &&
                        bus.tnew_M > bus.tuse_rt_D);
        end
    end

    assign mdHazard    = bus.md_use_D && mdBusy;
    assign stall       = rsHazard || rtHazard || mdHazard;
    assign bus.en_PC   = ~stall;
    assign bus.en_D    = ~stall;
    assign bus.flush_E = stall;
    assign bus.md_busy = mdBusy;

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: scoreboard bench for stall_ctrl. Expected decisions are
// queued as each stimulus vector is driven and compared when sampled.
module tb_stall_ctrl;
    import hazard_pkg::*;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuseRs;
        logic [1:0] tuseRt;
        logic [4:0] wrE;
        logic [4:0] wrM;
        logic       rwE;
        logic       rwM;
        logic [1:0] tnewE;
        logic [1:0] tnewM;
        logic       mdStart;
        logic       mdDiv;
        logic       mdUse;
        logic       expStall;
        logic       expBusy;
    } vec_t;

    typedef struct {
        string tag;
        logic  stall;
        logic  busy;
    } exp_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   expCnt;
    exp_t expQ[$];

    stall_ctrl_if bus ();

`ifdef STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave)
`ifdef STALL_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic vec_t idleVec();
        vec_t v;
        v        = '0;
        v.tuseRs = TUSE_NEVER;
        v.tuseRt = TUSE_NEVER;
        return v;
    endfunction

    task automatic driveVec(input vec_t v);
        bus.rs_D        = v.rs;
        bus.rt_D        = v.rt;
        bus.tuse_rs_D   = v.tuseRs;
        bus.tuse_rt_D   = v.tuseRt;
        bus.write_reg_E = v.wrE;
        bus.write_reg_M = v.wrM;
        bus.reg_write_E = v.rwE;
        bus.reg_write_M = v.rwM;
        bus.tnew_E      = v.tnewE;
        bus.tnew_M      = v.tnewM;
        bus.md_start_E  = v.mdStart;
        bus.md_is_div_E = v.mdDiv;
        bus.md_use_D    = v.mdUse;
    endtask

    task automatic checkOutputs(input exp_t e);
        checkVal({e.tag, ".flush"}, 32'(bus.flush_E), 32'(e.stall));
        checkVal({e.tag, ".enPC"},  32'(bus.en_PC),   32'(!e.stall));
        checkVal({e.tag, ".enD"},   32'(bus.en_D),    32'(!e.stall));
        checkVal({e.tag, ".busy"},  32'(bus.md_busy), 32'(e.busy));
    endtask

    // Called #1 after a rising edge; ends #1 after the next rising edge.
    task automatic step(input string tag, input vec_t v);
        exp_t e;
        driveVec(v);
        expQ.push_back('{tag, v.expStall, v.expBusy});
        #1;
        e = expQ.pop_front();
        checkOutputs(e);
        if (e.stall) expCnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic lwUseStall(input string tag);
        vec_t v;
        v = idleVec(); v.rs = 5'd1; v.tuseRs = 2'd1;
        v.wrE = 5'd1; v.rwE = 1'b1; v.tnewE = 2'd2; v.expStall = 1'b1;
        step(tag, v);
        step({tag, "Idle"}, idleVec());
    endtask

    task automatic mdSeq(input string tag, input logic isDiv, input int unsigned cycles);
        vec_t v;
        for (int unsigned k = 0; k <= cycles + 1; k++) begin
            v = idleVec();
            v.mdUse    = 1'b1;
            v.mdStart  = (k == 0);
            v.mdDiv    = isDiv;
            v.expStall = (k <= cycles);
            v.expBusy  = (k <= cycles);
            step($sformatf("%s%0d", tag, k), v);
        end
    endtask

    initial begin
        vec_t v;
        exp_t e;
        total   = 0;
        bad     = 0;
        expCnt  = 0;
        reset_n = 1'b0;
        driveVec(idleVec());
        #3;
        expQ.push_back('{"reset", 1'b0, 1'b0});
        e = expQ.pop_front();
        checkOutputs(e);
`ifdef STALL_CNT_EN
        checkVal("resetCnt", stall_count, 32'd0);
`endif
        #9 reset_n = 1'b1;
        @(posedge clk);
        #1;

        lwUseStall("lwUse");

        v = idleVec(); v.rs = 5'd1; v.tuseRs = 2'd1;
        v.wrM = 5'd1; v.rwM = 1'b1; v.tnewM = 2'd1;
        step("lwUseNext", v);

        v = idleVec(); v.rs = 5'd0; v.tuseRs = 2'd1;
        v.wrE = 5'd0; v.rwE = 1'b1; v.tnewE = 2'd2;
        step("zeroReg", v);

        v = idleVec(); v.rt = 5'd2; v.tuseRt = 2'd0;
        v.wrM = 5'd2; v.rwM = 1'b1; v.tnewM = 2'd0;
        step("beqFwd", v);

        v = idleVec(); v.rs = 5'd3; v.tuseRs = 2'd1;
        v.wrE = 5'd3; v.rwE = 1'b1; v.tnewE = 2'd1;
        step("tnewEqTuse", v);

        v = idleVec(); v.rt = 5'd4; v.tuseRt = 2'd1;
        v.wrE = 5'd4; v.rwE = 1'b1; v.tnewE = 2'd2; v.expStall = 1'b1;
        step("rtHazE", v);

        v = idleVec(); v.rs = 5'd5; v.tuseRs = 2'd3;
        v.wrE = 5'd5; v.rwE = 1'b1; v.tnewE = 2'd3;
        step("tuseNever", v);

        v = idleVec(); v.rs = 5'd7; v.tuseRs = 2'd0;
        v.wrE = 5'd7; v.rwE = 1'b0; v.tnewE = 2'd2;
        step("noRegWrite", v);

        v = idleVec(); v.rs = 5'd6; v.tuseRs = 2'd0;
        v.wrM = 5'd6; v.rwM = 1'b1; v.tnewM = 2'd1; v.expStall = 1'b1;
        step("rsHazM", v);

        v = idleVec(); v.rs = 5'd8; v.tuseRs = 2'd0;
        v.wrE = 5'd9; v.rwE = 1'b1; v.tnewE = 2'd2;
        step("regMiss", v);

        mdSeq("mult", 1'b0, 5);
        mdSeq("div", 1'b1, 10);

        // Busy without a HI/LO user must not stall.
        v = idleVec(); v.mdStart = 1'b1; v.expBusy = 1'b1;
        step("rstMult0", v);
        v = idleVec(); v.expBusy = 1'b1;
        step("rstMult1", v);

        driveVec(idleVec());
        #1 reset_n = 1'b0;
        #1;
        expQ.push_back('{"inReset", 1'b0, 1'b0});
        e = expQ.pop_front();
        checkOutputs(e);
        expCnt = 0;
`ifdef STALL_CNT_EN
        checkVal("inResetCnt", stall_count, 32'd0);
`endif
        #3 reset_n = 1'b1;
        #1;
        expQ.push_back('{"postReset", 1'b0, 1'b0});
        e = expQ.pop_front();
        checkOutputs(e);
        @(posedge clk);
        #1;
        v = idleVec(); v.mdUse = 1'b1;
        step("postResetUse", v);

        lwUseStall("cntA");
        lwUseStall("cntB");
        lwUseStall("cntC");
        mdSeq("cntMult", 1'b0, 5);
`ifdef STALL_CNT_EN
        checkVal("stallCntModel", stall_count, 32'(expCnt));
        checkVal("stallCnt", stall_count, 32'd9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
